turbo_encoder: RTL

// - Transmit-side counterpart of the max-product SISO decoder. Accepts an N-bit information block serially and runs two identical recursive systematic convolutional (RSC) encoders: RSC1 in natural order, RSC2 in interleaved order.
// - Emits encoder1_data / encoder2_data as BPSK-mapped floating-point matrices [BITS_PER_SYMBOL][SYMBOLS], the same shape the SISO stages consume.

---
 rtl/turbo_encoder_pkg.sv | 67 ++++++
 rtl/turbo_encoder_if.sv | 40 ++++
 rtl/turbo_encoder_rsc.sv | 35 +++
 rtl/turbo_encoder.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/turbo_encoder_pkg.sv
// Shared types, constants and helpers for the turbo encoder.
// Holds the interleaver permutation and the RSC step function.
package turbo_encoder_pkg;

  localparam int MEM  = 2;
  localparam int ROWS = 2;

  typedef logic        bit_t;
  typedef logic [15:0] llr_t;
  typedef logic [9:0]  block_t;

  typedef enum logic [1:0] {
    LOAD,
    ENCODE,
    OUTPUT
  } state_t;

  function automatic logic [31:0] plus_one(
    input bit single
  );
    return single ? 32'h3F80_0000 : 32'h0000_3C00;
  endfunction

  function automatic logic [31:0] minus_one(
    input bit single
  );
    return single ? 32'hBF80_0000 : 32'h0000_BC00;
  endfunction

  function automatic int interleave_index(
    input int i,
    input int n
  );
    return (7 * i + 3) % n;
  endfunction

  function automatic bit perm_ok(input int n);
    for (int i = 0; i < n; i++) begin
      if (interleave_index(i, n) < 0)
        return 1'b0;
      if (interleave_index(i, n) >= n)
        return 1'b0;
      for (int j = i + 1; j < n; j++)
        if (interleave_index(i, n) ==
            interleave_index(j, n))
          return 1'b0;
    end
    return 1'b1;
  endfunction

  // Returns {next_state, parity}. s[MEM-1] is the
  // newest delay tap, s[0] the oldest; generator bit
  // MEM weights the feedback node a itself.
  function automatic logic [MEM:0] rsc_step(
    input logic           u,
    input logic [MEM-1:0] s,
    input logic [MEM:0]   fb,
    input logic [MEM:0]   ff
  );
    logic a;
    logic p;
    a = u ^ (^(s & fb[MEM-1:0]));
    p = (ff[MEM] & a) ^ (^(s & ff[MEM-1:0]));
    return {a, s[MEM-1:1], p};
  endfunction

endpackage

// File: rtl/turbo_encoder_if.sv
// Block handshake bundle: serial bit input side and
// parallel BPSK matrix output side of the encoder.
interface turbo_encoder_if
  import turbo_encoder_pkg::*;
#(
  parameter int BITS    = 16,
  parameter int SYMBOLS = 10
);

  logic in_valid;
  logic in_ready;
  logic in_bit;
  logic out_valid;
  logic out_ready;
  logic [ROWS-1:0][SYMBOLS-1:0][BITS-1:0]
    encoder1_data_out;
  logic [ROWS-1:0][SYMBOLS-1:0][BITS-1:0]
    encoder2_data_out;

  modport master (
    output in_valid,
    output in_bit,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  encoder1_data_out,
    input  encoder2_data_out
  );

  modport slave (
    input  in_valid,
    input  in_bit,
    input  out_ready,
    output in_ready,
    output out_valid,
    output encoder1_data_out,
    output encoder2_data_out
  );

endinterface

// File: rtl/turbo_encoder_rsc.sv
// One recursive systematic convolutional encoder.
// Ports: clk, rstn, clear, en, u -> sys, par.
module rsc_encoder
  import turbo_encoder_pkg::*;
#(
  parameter logic [MEM:0] FEEDBACK    = 3'o7,
  parameter logic [MEM:0] FEEDFORWARD = 3'o5
) (
  input  logic clk,
  input  logic rstn,
  input  logic clear,
  input  logic en,
  input  logic u,
  output logic sys,
  output logic par
);

  logic [MEM-1:0] s;
  logic [MEM:0]   step;

  assign step = rsc_step(u, s, FEEDBACK,
                         FEEDFORWARD);
  assign sys  = u;
  assign par  = step[0];

  always_ff @(posedge clk) begin
    if (!rstn)
      s <= '0;
    else if (clear)
      s <= '0;
    else if (en)
      s <= step[MEM:1];
  end

endmodule

// File: rtl/turbo_encoder.sv
// Turbo encoder: serial load, two RSC passes, BPSK out.
// Ports: clk, rstn, bus (slave: in/out handshakes).
module turbo_encoder
  import turbo_encoder_pkg::*;
#(
  parameter int    BITS            = 16,
  parameter string PRECISION       = "HALF",
  parameter int    BITS_PER_SYMBOL = 2,
  parameter int    N               = 10,
  parameter int    SYMBOLS         = 10,
  parameter int    STATES          = 4,
  parameter logic [MEM:0] FEEDBACK    = 3'o7,
  parameter logic [MEM:0] FEEDFORWARD = 3'o5
) (
  input logic            clk,
  input logic            rstn,
  turbo_encoder_if.slave bus
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam bit SGL = (PRECISION == "SINGLE");
  localparam logic [BITS-1:0] P1 =
    BITS'(plus_one(SGL));
  localparam logic [BITS-1:0] M1 =
    BITS'(minus_one(SGL));

  if (SYMBOLS != N) begin : g_sym_chk
    $error("SYMBOLS must equal N");
  end
  if (BITS_PER_SYMBOL != ROWS) begin : g_bps_chk
    $error("BITS_PER_SYMBOL must be 2");
  end
  if (STATES != (1 << MEM)) begin : g_st_chk
    $error("STATES must be 2**MEMORY");
  end
  if (!perm_ok(N)) begin : g_pi_chk
    $error("interleaver is not a bijection");
  end

  state_t         state;
  state_t         next;
  logic [CW-1:0]  cnt;
  logic [CW-1:0]  pi;
  logic [N-1:0]   bits_q;
  logic           accept;
  logic           hs;
  logic           last;
  logic           step_en;
  logic           clear;
  logic           sys1, par1;
  logic           sys2, par2;

  assign accept = bus.in_valid & bus.in_ready;
  assign hs     = bus.out_valid & bus.out_ready;
  assign last   = (cnt == CW'(N - 1));
  assign pi     = CW'(interleave_index(int'(cnt), N));

  always_ff @(posedge clk) begin
    if (!rstn)
      state <= LOAD;
    else
      state <= next;
  end

  always_comb begin
    next = state;
    unique case (state)
      LOAD:    if (accept && last) next = ENCODE;
      ENCODE:  if (last) next = OUTPUT;
      OUTPUT:  if (hs) next = LOAD;
      default: next = LOAD;
    endcase
  end

  // in_ready is held low while rstn is asserted so
  // nothing is taken during reset.
  always_comb begin
    bus.in_ready = 1'b0;
    step_en      = 1'b0;
    clear        = hs;
    unique case (state)
      LOAD:    bus.in_ready = rstn;
      ENCODE:  step_en = 1'b1;
      default: ;
    endcase
  end

  rsc_encoder #(
    .FEEDBACK    (FEEDBACK),
    .FEEDFORWARD (FEEDFORWARD)
  ) u_rsc1 (
    .clk   (clk),
    .rstn  (rstn),
    .clear (clear),
    .en    (step_en),
    .u     (bits_q[cnt]),
    .sys   (sys1),
    .par   (par1)
  );

  rsc_encoder #(
    .FEEDBACK    (FEEDBACK),
    .FEEDFORWARD (FEEDFORWARD)
  ) u_rsc2 (
    .clk   (clk),
    .rstn  (rstn),
    .clear (clear),
    .en    (step_en),
    .u     (bits_q[pi]),
    .sys   (sys2),
    .par   (par2)
  );

  // out_valid rises one cycle after entering OUTPUT,
  // so the final column is settled a full cycle.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt                   <= '0;
      bits_q                <= '0;
      bus.out_valid         <= 1'b0;
      bus.encoder1_data_out <= '0;
      bus.encoder2_data_out <= '0;
    end else begin
      unique case (state)
        LOAD: begin
          if (accept) begin
            bits_q[cnt] <= bus.in_bit;
            cnt <= last ? '0 : cnt + 1'b1;
          end
        end
        ENCODE: begin
          bus.encoder1_data_out[0][cnt] <=
            sys1 ? P1 : M1;
          bus.encoder1_data_out[1][cnt] <=
            par1 ? P1 : M1;
          bus.encoder2_data_out[0][cnt] <=
            sys2 ? P1 : M1;
          bus.encoder2_data_out[1][cnt] <=
            par2 ? P1 : M1;
          cnt <= last ? '0 : cnt + 1'b1;
        end
        OUTPUT: begin
          bus.out_valid <= !hs;
          if (hs)
            cnt <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
